// File: rtl/mdl_mlkem_ntt128_xxx_bfu.sv
// Pipelined CT/GS butterfly for the 128-point ML-KEM NTT over Zq (q=3329), 3 register stages.
// Optional build macro MLKEM_BFU_INTT_HALF_EN: GS results are scaled by 2^-1 mod q.

module mdl_mlkem_ntt128_xxx_modmul #(
    parameter logic [11:0] PRM_KYBER_Q = 12'd3329
) (
    input  logic [11:0] iX,
    input  logic [11:0] iY,
    output logic [11:0] oP
);
    // Barrett reduction with k=24; product < q^2 < 2^24, remainder < 3q before correction
    localparam logic [12:0] BARRETT_M = 13'((1 << 24) / PRM_KYBER_Q);

    logic [23:0] prod;
    logic [11:0] qhat;
    logic [13:0] r0, r1, r2;

    always_comb begin
        prod = {12'd0, iX} * {12'd0, iY};
        qhat = 12'(({13'd0, prod} * {24'd0, BARRETT_M}) >> 24);
        r0   = prod[13:0] - 14'({2'd0, qhat} * {2'd0, PRM_KYBER_Q});
        r1   = (r0 >= {2'd0, PRM_KYBER_Q}) ? r0 - {2'd0, PRM_KYBER_Q} : r0;
        r2   = (r1 >= {2'd0, PRM_KYBER_Q}) ? r1 - {2'd0, PRM_KYBER_Q} : r1;
        oP   = r2[11:0];
    end
endmodule

module mdl_mlkem_ntt128_xxx_bfu #(
    parameter logic [11:0] PRM_KYBER_Q      = 12'd3329,
    parameter logic [6:0]  PRM_BF_PER_LAYER = 7'd64
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iSrcValid,
    output logic        oSrcReady,
    input  logic        iMode,
    input  logic [11:0] iA,
    input  logic [11:0] iB,
    input  logic [11:0] iZeta,
    output logic        oDstValid,
    input  logic        iDstReady,
    output logic [11:0] oA,
    output logic [11:0] oB,
    output logic [5:0]  oBfCnt,
    output logic        oLayerDone
);
    localparam logic [12:0] Q13 = {1'b0, PRM_KYBER_Q};

`ifdef MLKEM_BFU_INTT_HALF_EN
    function automatic logic [11:0] half_mod(input logic [11:0] x);
        logic [12:0] s;
        s = {1'b0, x} + (x[0] ? Q13 : 13'd0);
        return 12'(s >> 1);
    endfunction
`endif

    logic [3:1]  vld_pipe_q, vld_pipe_d;
    logic        s1_mode_q, s1_mode_d;
    logic [11:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_z_q, s1_z_d;
    logic        s2_mode_q, s2_mode_d;
    logic [11:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d, s2_z_q, s2_z_d;
    logic [11:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic        en;
    logic [11:0] s1_t, s2_p;
    logic [12:0] s1_sum, s1_dif, s2_sum, s2_dif;
    logic [11:0] s1_u, s1_d, ct_a, ct_b, gs_a, gs_b;

    mdl_mlkem_ntt128_xxx_modmul #(.PRM_KYBER_Q(PRM_KYBER_Q)) u_mul_ct (
        .iX(s1_b_q), .iY(s1_z_q), .oP(s1_t)
    );
    mdl_mlkem_ntt128_xxx_modmul #(.PRM_KYBER_Q(PRM_KYBER_Q)) u_mul_gs (
        .iX(s2_y_q), .iY(s2_z_q), .oP(s2_p)
    );

    assign en        = ~vld_pipe_q[3] | iDstReady;
    assign oSrcReady = en;
    assign oDstValid = vld_pipe_q[3];
    assign oA        = out_a_q;
    assign oB        = out_b_q;
    assign oBfCnt    = cnt_q;
    assign oLayerDone = done_q;

    always_comb begin
        // Stage 1 -> 2: GS add/sub; CT twiddle product
        s1_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        s1_dif = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        s1_u   = (s1_sum >= Q13) ? 12'(s1_sum - Q13) : s1_sum[11:0];
        s1_d   = (s1_a_q >= s1_b_q) ? s1_dif[11:0] : 12'(s1_dif + Q13);

        // Stage 2 -> 3: CT add/sub against t; GS product of d
        s2_sum = {1'b0, s2_x_q} + {1'b0, s2_y_q};
        s2_dif = {1'b0, s2_x_q} - {1'b0, s2_y_q};
        ct_a   = (s2_sum >= Q13) ? 12'(s2_sum - Q13) : s2_sum[11:0];
        ct_b   = (s2_x_q >= s2_y_q) ? s2_dif[11:0] : 12'(s2_dif + Q13);
`ifdef MLKEM_BFU_INTT_HALF_EN
        gs_a   = half_mod(s2_x_q);
        gs_b   = half_mod(s2_p);
`else
        gs_a   = s2_x_q;
        gs_b   = s2_p;
`endif
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_mode_d  = s1_mode_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_z_d     = s1_z_q;
        s2_mode_d  = s2_mode_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        s2_z_d     = s2_z_q;
        out_a_d    = out_a_q;
        out_b_d    = out_b_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;

        if (en) begin
            vld_pipe_d = {vld_pipe_q[2:1], iSrcValid};
            s1_mode_d  = iMode;
            s1_a_d     = iA;
            s1_b_d     = iB;
            s1_z_d     = iZeta;
            s2_mode_d  = s1_mode_q;
            s2_x_d     = s1_mode_q ? s1_u : s1_a_q;
            s2_y_d     = s1_mode_q ? s1_d : s1_t;
            s2_z_d     = s1_z_q;
            out_a_d    = s2_mode_q ? gs_a : ct_a;
            out_b_d    = s2_mode_q ? gs_b : ct_b;
        end

        if (vld_pipe_q[3] && iDstReady) begin
            if ({1'b0, cnt_q} == PRM_BF_PER_LAYER - 7'd1) begin
                cnt_d  = 6'd0;
                done_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            vld_pipe_q <= '0;
            s1_mode_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_z_q     <= '0;
            s2_mode_q  <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_z_q     <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_mode_q  <= s1_mode_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_z_q     <= s1_z_d;
            s2_mode_q  <= s2_mode_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            s2_z_q     <= s2_z_d;
            out_a_q    <= out_a_d;
            out_b_q    <= out_b_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_mdl_mlkem_ntt128_xxx_bfu.sv
// Self-checking bench for the ML-KEM butterfly unit: directed vectors, stall, layer counter,
// reset with data in flight and a randomized mixed-mode scoreboard run.

module tb_mdl_mlkem_ntt128_xxx_bfu;
    localparam int Q = 3329;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iSrcValid;
    logic        oSrcReady;
    logic        iMode;
    logic [11:0] iA, iB, iZeta;
    logic        oDstValid;
    logic        iDstReady;
    logic [11:0] oA, oB;
    logic [5:0]  oBfCnt;
    logic        oLayerDone;

    int n_cmp = 0;
    int n_err = 0;
    logic [23:0] exp_q[$];

    mdl_mlkem_ntt128_xxx_bfu dut (
        .iClk(iClk), .iRst(iRst),
        .iSrcValid(iSrcValid), .oSrcReady(oSrcReady), .iMode(iMode),
        .iA(iA), .iB(iB), .iZeta(iZeta),
        .oDstValid(oDstValid), .iDstReady(iDstReady),
        .oA(oA), .oB(oB), .oBfCnt(oBfCnt), .oLayerDone(oLayerDone)
    );

    always #5 iClk = ~iClk;

    // Reference butterfly from the mathematical definition (modular arithmetic on ints)
    function automatic logic [23:0] ref_bf(input int mode, input int a, input int b, input int z);
        int ea, eb, t;
        if (mode == 0) begin
            t  = (b * z) % Q;
            ea = (a + t) % Q;
            eb = (a - t + Q) % Q;
        end else begin
            ea = (a + b) % Q;
            eb = (((a - b + Q) % Q) * z) % Q;
`ifdef MLKEM_BFU_INTT_HALF_EN
            ea = (ea * 1665) % Q;
            eb = (eb * 1665) % Q;
`endif
        end
        return {12'(ea), 12'(eb)};
    endfunction

    task automatic next_cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iSrcValid = 1'b0; iDstReady = 1'b1;
        iMode = 1'b0; iA = '0; iB = '0; iZeta = '0;
        repeat (3) next_cycle();
        iRst = 1'b0;
        #1;
        n_cmp++;
        if (oDstValid !== 1'b0 || oA !== 12'd0 || oB !== 12'd0 || oBfCnt !== 6'd0 || oLayerDone !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b a=%0d b=%0d cnt=%0d done=%b, want all zero",
                     oDstValid, oA, oB, oBfCnt, oLayerDone);
        end
        n_cmp++;
        if (oSrcReady !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", oSrcReady);
        end
        next_cycle();
    endtask

    task automatic test_directed();
        int md[5], va[5], vb[5], vz[5], ea[5], eb[5];
        int lat;
        md = '{0, 0, 0, 1, 1};
        va = '{1, 3328, 0, 5, 0};
        vb = '{1, 1, 5, 3, 1};
        vz = '{17, 1, 1, 2, 1};
`ifdef MLKEM_BFU_INTT_HALF_EN
        ea = '{18, 0, 5, 4, 1665};
        eb = '{3313, 3327, 3324, 2, 1664};
`else
        ea = '{18, 0, 5, 8, 1};
        eb = '{3313, 3327, 3324, 4, 3328};
`endif
        for (int i = 0; i < 5; i++) begin
            iMode = md[i][0]; iA = 12'(va[i]); iB = 12'(vb[i]); iZeta = 12'(vz[i]);
            iSrcValid = 1'b1; iDstReady = 1'b1;
            #1;
            n_cmp++;
            if (oSrcReady !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_ready: got %b want 1", i, oSrcReady);
            end
            next_cycle();
            iSrcValid = 1'b0;
            lat = 1;
            while (oDstValid !== 1'b1 && lat < 20) begin
                next_cycle();
                lat++;
            end
            n_cmp++;
            if (lat != 3) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d want 3", i, lat);
            end
            n_cmp++;
            if (oA !== 12'(ea[i]) || oB !== 12'(eb[i])) begin
                n_err++;
                $display("FAIL dir%0d_data: got a=%0d b=%0d want a=%0d b=%0d", i, oA, oB, ea[i], eb[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        int sent = 0, recv = 0, cyc = 0;
        logic        prev_stall = 1'b0;
        logic [11:0] prev_a = '0, prev_b = '0;
        logic [23:0] e;
        exp_q.delete();
        while (recv < 10 && cyc < 200) begin
            iMode = 1'b0;
            iA = 12'($urandom_range(0, Q - 1));
            iB = 12'($urandom_range(0, Q - 1));
            iZeta = 12'($urandom_range(0, Q - 1));
            iSrcValid = (sent < 10);
            iDstReady = !(cyc >= 5 && cyc < 10);
            #1;
            if (prev_stall) begin
                n_cmp++;
                if (oDstValid !== 1'b1 || oA !== prev_a || oB !== prev_b) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b a=%0d b=%0d want v=1 a=%0d b=%0d",
                             oDstValid, oA, oB, prev_a, prev_b);
                end
            end
            if (!iDstReady && oDstValid) begin
                n_cmp++;
                if (oSrcReady !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_ready: got %b want 0", oSrcReady);
                end
            end
            if (iSrcValid && oSrcReady) begin
                exp_q.push_back(ref_bf(0, int'(iA), int'(iB), int'(iZeta)));
                sent++;
            end
            if (oDstValid && iDstReady) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stall_extra: got a=%0d b=%0d want no output", oA, oB);
                end else begin
                    e = exp_q.pop_front();
                    if ({oA, oB} !== e) begin
                        n_err++;
                        $display("FAIL stall_data%0d: got a=%0d b=%0d want a=%0d b=%0d",
                                 recv, oA, oB, e[23:12], e[11:0]);
                    end
                end
                recv++;
            end
            prev_stall = oDstValid && !iDstReady;
            prev_a = oA; prev_b = oB;
            next_cycle();
        end
        iSrcValid = 1'b0;
        n_cmp++;
        if (recv != 10 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_count: got recv=%0d left=%0d want recv=10 left=0", recv, exp_q.size());
        end
    endtask

    task automatic test_layer_count();
        int sent = 0, xfers = 0, cyc = 0, pulses = 0, extra = 0;
        logic exp_done = 1'b0, exp_done_nxt;
        logic [23:0] e;
        iRst = 1'b1; iSrcValid = 1'b0;
        next_cycle();
        iRst = 1'b0;
        exp_q.delete();
        while ((xfers < 130 || extra < 3) && cyc < 400) begin
            iMode = 1'($urandom_range(0, 1));
            iA = 12'($urandom_range(0, Q - 1));
            iB = 12'($urandom_range(0, Q - 1));
            iZeta = 12'($urandom_range(0, Q - 1));
            iSrcValid = (sent < 130);
            iDstReady = 1'b1;
            #1;
            n_cmp++;
            if (oBfCnt !== 6'(xfers % 64) || oLayerDone !== exp_done) begin
                n_err++;
                $display("FAIL layer_cnt@%0d: got cnt=%0d done=%b want cnt=%0d done=%b",
                         xfers, oBfCnt, oLayerDone, xfers % 64, exp_done);
            end
            if (oLayerDone === 1'b1) pulses++;
            if (iSrcValid && oSrcReady) begin
                exp_q.push_back(ref_bf(int'(iMode), int'(iA), int'(iB), int'(iZeta)));
                sent++;
            end
            exp_done_nxt = 1'b0;
            if (oDstValid && iDstReady) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({oA, oB} !== e) begin
                        n_err++;
                        $display("FAIL layer_data%0d: got a=%0d b=%0d want a=%0d b=%0d",
                                 xfers, oA, oB, e[23:12], e[11:0]);
                    end
                end
                xfers++;
                exp_done_nxt = (xfers % 64 == 0);
            end
            if (xfers >= 130) extra++;
            exp_done = exp_done_nxt;
            next_cycle();
            cyc++;
        end
        iSrcValid = 1'b0;
        n_cmp++;
        if (pulses != 2 || xfers != 130 || oBfCnt !== 6'd2) begin
            n_err++;
            $display("FAIL layer_total: got pulses=%0d xfers=%0d cnt=%0d want 2/130/2", pulses, xfers, oBfCnt);
        end
    endtask

    task automatic test_reset_inflight();
        iDstReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iMode = 1'b0; iA = 12'(i + 1); iB = 12'(i + 2); iZeta = 12'd7;
            iSrcValid = 1'b1;
            next_cycle();
        end
        iSrcValid = 1'b0;
        iRst = 1'b1;
        next_cycle();
        n_cmp++;
        if (oDstValid !== 1'b0 || oBfCnt !== 6'd0) begin
            n_err++;
            $display("FAIL rst_flight: got v=%b cnt=%0d want v=0 cnt=0", oDstValid, oBfCnt);
        end
        iRst = 1'b0;
        iDstReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            n_cmp++;
            if (oDstValid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_stale%0d: got v=%b want 0", i, oDstValid);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int sent = 0, recv = 0, cyc = 0;
        logic [23:0] e;
        exp_q.delete();
        while (recv < 300 && cyc < 5000) begin
            iMode = 1'($urandom_range(0, 1));
            iA = 12'($urandom_range(0, Q - 1));
            iB = 12'($urandom_range(0, Q - 1));
            iZeta = 12'($urandom_range(0, Q - 1));
            iSrcValid = (sent < 300) && ($urandom_range(0, 3) != 0);
            iDstReady = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if (oSrcReady !== (!oDstValid || iDstReady)) begin
                n_err++;
                $display("FAIL rand_ready: got %b want %b", oSrcReady, (!oDstValid || iDstReady));
            end
            if (iSrcValid && oSrcReady) begin
                exp_q.push_back(ref_bf(int'(iMode), int'(iA), int'(iB), int'(iZeta)));
                sent++;
            end
            if (oDstValid && iDstReady) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: got a=%0d b=%0d want no output", oA, oB);
                end else begin
                    e = exp_q.pop_front();
                    if ({oA, oB} !== e) begin
                        n_err++;
                        $display("FAIL rand_data%0d: got a=%0d b=%0d want a=%0d b=%0d",
                                 recv, oA, oB, e[23:12], e[11:0]);
                    end
                end
                recv++;
            end
            next_cycle();
            cyc++;
        end
        iSrcValid = 1'b0;
        n_cmp++;
        if (recv != 300 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_count: got recv=%0d left=%0d want recv=300 left=0", recv, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_layer_count();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
